// File: rtl/spi_target_if.sv
// Pin-side and byte-side signal bundle of the SPI target.
// master: controller pins plus byte source/sink; slave: the target.
interface spi_target_if;
   logic       sclk;
   logic       pico;
   logic       cs;
   logic       poci;
   logic       poci_oe;
   logic       cpol;
   logic       cpha;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   modport master (
      output sclk, pico, cs, cpol, cpha,
      output tx_data, tx_valid,
      input  poci, poci_oe, tx_ready,
      input  rx_data, rx_valid, busy
   );

   modport slave (
      input  sclk, pico, cs, cpol, cpha,
      input  tx_data, tx_valid,
      output poci, poci_oe, tx_ready,
      output rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_target.sv
// Oversampled SPI target, modes 0-3, byte-wide rx strobe and tx slot.
// Define SPI_TARGET_ECHO_EN to make the fill byte the last received byte.
module spi_target #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
   input logic         clock,
   input logic         reset,
   spi_target_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t state;
   state_t state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] pico_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] cs_live;
   logic                   sclk_hist;
   logic                   cs_hist;
   logic                   cs_armed;
   logic                   cpol_q;
   logic                   cpha_q;
   logic [7:0]             tx_byte;
   logic [7:0]             rx_shift;
   logic [7:0]             rx_q;
   logic [2:0]             bit_cnt;
   logic                   poci_q;
   logic                   oe_q;
   logic                   rx_valid_q;

   logic       sclk_s;
   logic       pico_s;
   logic       cs_s;
   logic       sclk_rise;
   logic       sclk_fall;
   logic       sample_edge;
   logic       shift_edge;
   logic       cs_fall;
   logic       cs_rise;
   logic       last_bit;
   logic [7:0] fill_byte;
   logic [7:0] load_byte;
   logic       tx_ready_c;
   logic       busy_c;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign pico_s = pico_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_hist;
   assign sclk_fall = ~sclk_s & sclk_hist;

   assign sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
   assign shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

   // A cs low already present at reset release must not start a frame.
   assign cs_fall  = cs_armed & cs_hist & ~cs_s;
   assign cs_rise  = cs_s & ~cs_hist;
   assign last_bit = sample_edge & (bit_cnt == 3'd7);

`ifdef SPI_TARGET_ECHO_EN
   assign fill_byte = rx_q;
`else
   assign fill_byte = FILL_BYTE;
`endif

   assign load_byte = bus.tx_valid ? bus.tx_data : fill_byte;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tx_ready_c = 1'b0;
      busy_c     = 1'b1;
      unique case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (cs_fall) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            tx_ready_c = 1'b1;
            state_nxt  = cs_rise ? IDLE : SHIFT;
         end
         SHIFT: begin
            if (cs_rise) begin
               state_nxt = IDLE;
            end else if (last_bit) begin
               state_nxt = LOAD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sclk_sync  <= '0;
         pico_sync  <= '0;
         cs_sync    <= '1;
         cs_live    <= '0;
         sclk_hist  <= 1'b0;
         cs_hist    <= 1'b1;
         cs_armed   <= 1'b0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         tx_byte    <= 8'h00;
         rx_shift   <= 8'h00;
         rx_q       <= 8'h00;
         bit_cnt    <= 3'd0;
         poci_q     <= 1'b0;
         oe_q       <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         pico_sync <= {pico_sync[SYNC_STAGES-2:0], bus.pico};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
         cs_live   <= {cs_live[SYNC_STAGES-2:0], 1'b1};
         sclk_hist <= sclk_s;
         cs_hist   <= cs_s;
         cs_armed  <= cs_armed | (cs_live[SYNC_STAGES-1] & cs_s);

         rx_valid_q <= 1'b0;
         oe_q       <= (state != IDLE) && (state_nxt != IDLE);

         unique case (state)
            IDLE: begin
               cpol_q <= bus.cpol;
               cpha_q <= bus.cpha;
               poci_q <= 1'b0;
            end
            LOAD: begin
               tx_byte <= load_byte;
               poci_q  <= load_byte[7];
               bit_cnt <= 3'd0;
            end
            SHIFT: begin
               if (sample_edge) begin
                  rx_shift <= {rx_shift[6:0], pico_s};
                  bit_cnt  <= bit_cnt + 3'd1;
               end
               // Drive the bit the next sample edge will take.
               if (shift_edge) begin
                  poci_q <= tx_byte[~bit_cnt];
               end
               if (last_bit) begin
                  rx_q       <= {rx_shift[6:0], pico_s};
                  rx_valid_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.poci     = poci_q;
   assign bus.poci_oe  = oe_q;
   assign bus.tx_ready = tx_ready_c;
   assign bus.rx_data  = rx_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = busy_c;
endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target: byte-level SPI controller model,
// tx feeder and rx monitor, checked against expected frame contents.
module tb_spi_target;
   localparam int         SYNC = 2;
   localparam logic [7:0] FILL = 8'hFF;
`ifdef SPI_TARGET_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;

   spi_target_if bus ();

   spi_target #(
      .SYNC_STAGES(SYNC),
      .FILL_BYTE  (FILL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
   endtask

   logic [7:0] rx_log[$];
   int rdy_cnt = 0;
   int acc_cnt = 0;

   always @(negedge clock) begin
      if (bus.rx_valid === 1'b1) rx_log.push_back(bus.rx_data);
      if (bus.tx_ready === 1'b1) rdy_cnt++;
      if (bus.tx_ready === 1'b1 && bus.tx_valid === 1'b1) acc_cnt++;
   end

   logic [7:0] mo_q[$];
   logic [7:0] mi_q[$];
   logic [7:0] feed_q[$];
   logic [7:0] exp_feed[$];
   logic [7:0] last_rx;
   bit         frame_done;

   function automatic logic [7:0] fill_at(input int k);
      if (!ECHO) return FILL;
      return (k == 0) ? last_rx : mo_q[k-1];
   endfunction

   task automatic feed_show();
      if (feed_q.size() != 0) begin
         bus.tx_valid = 1'b1;
         bus.tx_data  = feed_q[0];
      end else begin
         bus.tx_valid = 1'b0;
      end
   endtask

   task automatic feed_proc();
      feed_show();
      while (!frame_done) begin
         @(negedge clock);
         if (bus.tx_ready === 1'b1 && bus.tx_valid === 1'b1) begin
            @(posedge clock);
            #1;
            void'(feed_q.pop_front());
            feed_show();
         end
      end
      bus.tx_valid = 1'b0;
   endtask

   task automatic late_proc();
      int k;
      k = 0;
      while (bus.tx_ready !== 1'b1 && k < 400) begin
         @(negedge clock);
         k++;
      end
      chk("late_slot_seen", 32'(k < 400), 1);
      @(negedge clock);
      bus.tx_data  = 8'h5A;
      bus.tx_valid = 1'b1;
      repeat (3) @(negedge clock);
      bus.tx_valid = 1'b0;
   endtask

   // Controller: drives nbits of mo_q MSB-first, collects poci bytes.
   task automatic ctrl(input logic [1:0] mode, input int nbits,
                       input int hp, input bit cs_last,
                       input int rst_bit);
      logic       cpol_v;
      logic       cpha_v;
      logic [7:0] cur;
      logic [7:0] b;
      logic       d;
      cpol_v = mode[1];
      cpha_v = mode[0];
      cur    = 8'h00;
      mi_q.delete();
      @(negedge clock);
      bus.cpol = cpol_v;
      bus.cpha = cpha_v;
      bus.sclk = cpol_v;
      repeat (6) @(negedge clock);
      bus.cs = 1'b0;
      repeat (8) @(negedge clock);
      for (int i = 0; i < nbits; i++) begin
         b = mo_q[i/8];
         d = b[7 - (i % 8)];
         if (!cpha_v) begin
            bus.pico = d;
            repeat (hp) @(negedge clock);
            cur = {cur[6:0], bus.poci};
            bus.sclk = ~cpol_v;
            if (cs_last && i == nbits - 1) bus.cs = 1'b1;
            repeat (hp) @(negedge clock);
            bus.sclk = cpol_v;
         end else begin
            bus.sclk = ~cpol_v;
            bus.pico = d;
            repeat (hp) @(negedge clock);
            cur = {cur[6:0], bus.poci};
            bus.sclk = cpol_v;
            if (cs_last && i == nbits - 1) bus.cs = 1'b1;
            repeat (hp) @(negedge clock);
         end
         if (i % 8 == 7) mi_q.push_back(cur);
         if (i == rst_bit) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_poci", bus.poci, 0);
            chk("rst_oe", bus.poci_oe, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_rdy", bus.tx_ready, 0);
            chk("rst_rxd", bus.rx_data, 0);
            @(negedge clock);
            reset = 1'b0;
            repeat (6) @(negedge clock);
            chk("rst_ignore_busy", bus.busy, 0);
         end
      end
      repeat (hp) @(negedge clock);
      bus.cs = 1'b1;
      repeat (SYNC + 2) @(negedge clock);
      chk("oe_off", bus.poci_oe, 0);
      repeat (6) @(negedge clock);
      frame_done = 1'b1;
   endtask

   task automatic run_frame(input logic [1:0] mode, input int nbits,
                            input int hp, input bit cs_last,
                            input int rst_bit, input bit late);
      frame_done = 1'b0;
      fork
         ctrl(mode, nbits, hp, cs_last, rst_bit);
         feed_proc();
         if (late) late_proc();
      join
   endtask

   task automatic do_frame(input string tag, input logic [1:0] mode,
                           input int hp, input int nb);
      int rx_b;
      int rdy_b;
      int acc_b;
      int nacc;
      logic [7:0] got;
      rx_b  = rx_log.size();
      rdy_b = rdy_cnt;
      acc_b = acc_cnt;
      exp_feed = feed_q;
      run_frame(mode, nb * 8, hp, 1'b0, -1, 1'b0);
      chk({tag, "_nrx"}, rx_log.size() - rx_b, nb);
      for (int k = 0; k < nb; k++) begin
         got = (rx_b + k < rx_log.size()) ? rx_log[rx_b + k] : 8'h00;
         chk($sformatf("%s_rx%0d", tag, k), got, mo_q[k]);
         chk($sformatf("%s_poci%0d", tag, k), mi_q[k],
             (k < exp_feed.size()) ? exp_feed[k] : fill_at(k));
      end
      chk({tag, "_slots"}, rdy_cnt - rdy_b, nb + 1);
      nacc = (exp_feed.size() < nb + 1) ? exp_feed.size() : nb + 1;
      chk({tag, "_acc"}, acc_cnt - acc_b, nacc);
      last_rx = mo_q[nb-1];
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   initial begin
      int rx_b;
      int rdy_b;
      int acc_b;
      int nb;
      int nf;
      int hp;
      logic [1:0] md;
      logic [7:0] got;

      bus.sclk     = 1'b0;
      bus.pico     = 1'b0;
      bus.cs       = 1'b1;
      bus.cpol     = 1'b0;
      bus.cpha     = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      reset        = 1'b1;
      last_rx      = 8'h00;
      #12;
      chk("reset_poci", bus.poci, 0);
      chk("reset_oe", bus.poci_oe, 0);
      chk("reset_rdy", bus.tx_ready, 0);
      chk("reset_rxd", bus.rx_data, 0);
      chk("reset_rxv", bus.rx_valid, 0);
      chk("reset_busy", bus.busy, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      mo_q   = '{8'h3C};
      feed_q = '{8'hA5};
      do_frame("m0", 2'd0, 4, 1);

      for (int m = 1; m < 4; m++) begin
         mo_q = '{8'h81, 8'h7E};
         feed_q.delete();
         do_frame($sformatf("mode%0d", m), 2'(m), 4, 2);
      end

      for (int r = 0; r < 8; r++) begin
         md = 2'($urandom_range(0, 3));
         nb = $urandom_range(1, 3);
         hp = $urandom_range(4, 7);
         nf = $urandom_range(0, nb);
         mo_q.delete();
         feed_q.delete();
         for (int k = 0; k < nb; k++) mo_q.push_back(8'($urandom_range(0, 255)));
         for (int k = 0; k < nf; k++) feed_q.push_back(8'($urandom_range(0, 255)));
         do_frame($sformatf("rnd%0d", r), md, hp, nb);
      end

      // Frame cut after 5 bits.
      mo_q = '{8'($urandom_range(0, 255))};
      feed_q.delete();
      rx_b = rx_log.size();
      run_frame(2'($urandom_range(0, 3)), 5, 5, 1'b0, -1, 1'b0);
      chk("part_nrx", rx_log.size() - rx_b, 0);
      chk("part_rxd", bus.rx_data, last_rx);
      chk("part_busy", bus.busy, 0);

      // cs rises together with the 8th sample edge.
      for (int m = 0; m < 4; m += 3) begin
         mo_q = '{8'($urandom_range(0, 255))};
         feed_q.delete();
         rx_b  = rx_log.size();
         rdy_b = rdy_cnt;
         run_frame(2'(m), 8, 4, 1'b1, -1, 1'b0);
         chk("sim_nrx", rx_log.size() - rx_b, 1);
         got = (rx_b < rx_log.size()) ? rx_log[rx_b] : 8'h00;
         chk("sim_rx", got, mo_q[0]);
         chk("sim_poci", mi_q[0], fill_at(0));
         chk("sim_slots", rdy_cnt - rdy_b, 1);
         chk("sim_busy", bus.busy, 0);
         last_rx = mo_q[0];
      end

      // Reset pulse after bit 3; rest of that frame must be ignored.
      mo_q = '{8'($urandom_range(0, 255))};
      feed_q.delete();
      rx_b = rx_log.size();
      run_frame(2'd0, 8, 4, 1'b0, 2, 1'b0);
      chk("rst_nrx", rx_log.size() - rx_b, 0);
      last_rx = 8'h00;
      mo_q   = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      feed_q = '{8'($urandom_range(0, 255))};
      do_frame("post_rst", 2'($urandom_range(0, 3)), 4, 2);

      // tx_valid raised one cycle after the load slot.
      mo_q = '{8'($urandom_range(0, 255))};
      feed_q.delete();
      rx_b  = rx_log.size();
      acc_b = acc_cnt;
      run_frame(2'd0, 8, 4, 1'b0, -1, 1'b1);
      chk("late_nrx", rx_log.size() - rx_b, 1);
      chk("late_poci", mi_q[0], fill_at(0));
      chk("late_acc", acc_cnt - acc_b, 0);
      last_rx = mo_q[0];

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
